// File: rtl/tower_frame_writer.sv
// tower_frame_writer: zero-suppresses a calorimeter tower stream into a frame memory
// and publishes the frame's tower count and maximum ET.
module tower_frame_writer #(
  parameter int ETA_W = 8,
  parameter int PHI_W = 8,
  parameter int ET_W  = 8,
  parameter int E_W   = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ETA_W-1:0]  in_eta,
  input  logic [PHI_W-1:0]  in_phi,
  input  logic [ET_W-1:0]   in_et,
  input  logic [E_W-1:0]    in_e,
  input  logic              in_last,
  input  logic [ET_W-1:0]   et_thresh,
  output logic              frame_valid,
  output logic [AW:0]       numtowers,
  output logic [ET_W-1:0]   max_et,
  output logic [AW-1:0]     max_idx,
  output logic              overflow,
  input  logic              frame_ack,
  input  logic [AW-1:0]     rd_addr,
  output logic [ETA_W-1:0]  rd_eta,
  output logic [PHI_W-1:0]  rd_phi,
  output logic [ET_W-1:0]   rd_et,
  output logic [E_W-1:0]    rd_e
);
  localparam int W = ETA_W + PHI_W + ET_W + E_W;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [W-1:0] mem [DEPTH];
  logic accept, keep, full, wr;
  assign accept = in_valid & in_ready;
  assign keep   = in_et >= et_thresh;
  assign full   = numtowers == (AW+1)'(DEPTH);
  assign wr     = accept & keep & ~full;
  // Frame memory is never reset; read-before-write gives old data on address collision.
  always_ff @(posedge clk)
    if (wr) mem[numtowers[AW-1:0]] <= {in_eta, in_phi, in_et, in_e};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rd_eta, rd_phi, rd_et, rd_e} <= '0;
    else        {rd_eta, rd_phi, rd_et, rd_e} <= mem[rd_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      numtowers   <= '0;
      max_et      <= '0;
      max_idx     <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (wr) begin
            numtowers <= numtowers + 1'b1;
            if (in_et > max_et) begin
              max_et  <= in_et;
              max_idx <= numtowers[AW-1:0];
            end
          end
          if (accept & keep & full) overflow <= 1'b1;
          if (accept & in_last) begin
            state       <= HOLD;
            in_ready    <= 1'b0;
            frame_valid <= 1'b1;
          end
        end
        default: if (frame_ack) begin
          state       <= FILL;
          in_ready    <= 1'b1;
          frame_valid <= 1'b0;
          numtowers   <= '0;
          max_et      <= '0;
          max_idx     <= '0;
          overflow    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tower_frame_writer.sv
// tb_tower_frame_writer: scoreboard bench for tower_frame_writer
module tb_tower_frame_writer;
  localparam int AW = 10, DEPTH = 1024;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, frame_ack = 1'b0;
  logic in_ready, frame_valid, overflow;
  logic [7:0] in_eta = '0, in_phi = '0, in_et = '0, in_e = '0, et_thresh = '0;
  logic [AW:0] numtowers;
  logic [7:0] max_et, rd_eta, rd_phi, rd_et, rd_e;
  logic [AW-1:0] max_idx, rd_addr = '0;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  int exp_n;
  logic [7:0] exp_max;
  logic [AW-1:0] exp_idx;
  logic exp_ovf;

  always #5 clk = ~clk;

  tower_frame_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_eta(in_eta), .in_phi(in_phi), .in_et(in_et), .in_e(in_e), .in_last(in_last),
    .et_thresh(et_thresh), .frame_valid(frame_valid), .numtowers(numtowers),
    .max_et(max_et), .max_idx(max_idx), .overflow(overflow), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_eta(rd_eta), .rd_phi(rd_phi), .rd_et(rd_et), .rd_e(rd_e)
  );

  task automatic model_clear();
    exp_q.delete();
    exp_n = 0;
    exp_max = '0;
    exp_idx = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] et, input logic last);
    int w = 0;
    logic [7:0] eta = 8'($urandom), phi = 8'($urandom), e = 8'($urandom);
    in_valid = 1'b1; in_eta = eta; in_phi = phi; in_et = et; in_e = e; in_last = last;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    if (et >= et_thresh) begin
      if (exp_n < DEPTH) begin
        exp_q.push_back({eta, phi, et, e});
        if (et > exp_max) begin exp_max = et; exp_idx = AW'(exp_n); end
        exp_n++;
      end else exp_ovf = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_frame(input string name);
    logic [31:0] exp;
    checks += 5;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL %s frame_valid: got %b want 1", name, frame_valid); end
    if (numtowers !== (AW+1)'(exp_n)) begin errors++; $display("FAIL %s numtowers: got %0d want %0d", name, numtowers, exp_n); end
    if (max_et !== exp_max) begin errors++; $display("FAIL %s max_et: got %0d want %0d", name, max_et, exp_max); end
    if (max_idx !== exp_idx) begin errors++; $display("FAIL %s max_idx: got %0d want %0d", name, max_idx, exp_idx); end
    if (overflow !== exp_ovf) begin errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, exp_ovf); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({rd_eta, rd_phi, rd_et, rd_e} !== exp) begin
        errors++;
        $display("FAIL %s rd[%0d]: got %h want %h", name, i, {rd_eta, rd_phi, rd_et, rd_e}, exp);
      end
    end
  endtask

  task automatic ack(input string name);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checks += 4;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL %s ack frame_valid: got %b want 0", name, frame_valid); end
    if (numtowers !== '0) begin errors++; $display("FAIL %s ack numtowers: got %0d want 0", name, numtowers); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ack in_ready: got %b want 1", name, in_ready); end
    if ({max_et, max_idx, overflow} !== '0) begin errors++; $display("FAIL %s ack max/ovf: got %0d/%0d/%b want 0", name, max_et, max_idx, overflow); end
    model_clear();
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b want 0", name, in_ready); end
    if ({frame_valid, numtowers, max_et, max_idx, overflow} !== '0) begin
      errors++;
      $display("FAIL %s frame: got fv=%b n=%0d max=%0d idx=%0d ovf=%b want 0", name, frame_valid, numtowers, max_et, max_idx, overflow);
    end
    if ({rd_eta, rd_phi, rd_et, rd_e} !== '0) begin errors++; $display("FAIL %s rd: got %h want 0", name, {rd_eta, rd_phi, rd_et, rd_e}); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_after_clk in_ready: got %b want 1", in_ready); end
    model_clear();
  endtask

  task automatic test_basic();
    logic [7:0] ets [5] = '{8'd3, 8'd9, 8'd9, 8'd2, 8'd7};
    et_thresh = 8'd0;
    foreach (ets[i]) send(ets[i], i == 4);
    check_frame("basic");
    ack("basic");
  endtask

  task automatic test_thresh_and_ignored_ack();
    et_thresh = 8'd5;
    send(8'd4, 1'b0);
    send(8'd6, 1'b0);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checks++;
    if (numtowers !== 11'(exp_n)) begin errors++; $display("FAIL fill_ack numtowers: got %0d want %0d", numtowers, exp_n); end
    send(8'd5, 1'b0);
    send(8'd1, 1'b1);
    check_frame("thresh");
  endtask

  task automatic test_hold();
    logic [AW:0] held = 11'(exp_n);
    in_valid = 1'b1; in_et = 8'd200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold in_ready cyc %0d: got %b want 0", i, in_ready); end
      if (numtowers !== held) begin errors++; $display("FAIL hold numtowers cyc %0d: got %0d want %0d", i, numtowers, held); end
    end
    in_valid = 1'b0;
    ack("hold");
  endtask

  task automatic test_full();
    et_thresh = 8'd0;
    for (int i = 0; i < DEPTH + 2; i++) send(i >= DEPTH ? 8'd255 : 8'($urandom_range(1, 250)), i == DEPTH + 1);
    check_frame("full");
    ack("full");
  endtask

  task automatic test_empty();
    et_thresh = 8'd10;
    send(8'd3, 1'b1);
    check_frame("empty");
    ack("empty");
  endtask

  task automatic test_reset_mid();
    et_thresh = 8'd0;
    for (int i = 0; i < 3; i++) send(8'(20 + i), 1'b0);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    send(8'd40, 1'b0);
    send(8'd50, 1'b1);
    check_frame("after_reset");
    ack("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresh_and_ignored_ack();
    test_hold();
    test_full();
    test_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
